// File: rtl/comperator_axi_ip_v1_0_frame_tx.sv
// Frame transmitter: counts raw pixels into an AXI4-Stream video frame
// with a single output register stage (tuser on first pixel, tlast per line).
module comperator_axi_ip_v1_0_frame_tx #(
  parameter int DATA_WIDTH = 24,
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int CNT_WIDTH  = 12
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  go,
  input  logic [DATA_WIDTH-1:0] pix_data,
  input  logic                  pix_valid,
  output logic                  pix_ready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tuser,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  busy,
  output logic                  frame_done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] X_LAST =
    CNT_WIDTH'(H_ACTIVE - 1);
  localparam logic [CNT_WIDTH-1:0] Y_LAST =
    CNT_WIDTH'(V_ACTIVE - 1);
  localparam logic [CNT_WIDTH-1:0] ONE =
    CNT_WIDTH'(1);

  state_t               state_q;
  state_t               state_d;
  logic [CNT_WIDTH-1:0] x_q;
  logic [CNT_WIDTH-1:0] y_q;

  logic in_xfer;
  logic out_xfer;
  logic x_last;
  logic y_last;
  logic frame_end;
  logic start;

  assign x_last    = (x_q == X_LAST);
  assign y_last    = (y_q == Y_LAST);
  assign frame_end = x_last && y_last;
  assign start     = (state_q == IDLE) && go;

  // The output register can take a new pixel when empty or draining now.
  assign pix_ready = (state_q == RUN) &&
                     (!m_axis_tvalid || m_axis_tready);
  assign in_xfer   = pix_valid && pix_ready;
  assign out_xfer  = m_axis_tvalid && m_axis_tready;
  assign busy      = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (go) state_d = RUN;
      end
      RUN: begin
        if (in_xfer && frame_end) state_d = DRAIN;
      end
      DRAIN: begin
        if (out_xfer) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      unique case (1'b1)
        start: begin
          x_q <= '0;
          y_q <= '0;
        end
        in_xfer: begin
          if (x_last) begin
            x_q <= '0;
            y_q <= y_last ? '0 : y_q + ONE;
          end else begin
            x_q <= x_q + ONE;
          end
        end
        default: begin
          x_q <= x_q;
          y_q <= y_q;
        end
      endcase
    end
  end

  // A held beat keeps its payload; only tvalid drops once it is taken.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      m_axis_tdata  <= '0;
      m_axis_tuser  <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tvalid <= 1'b0;
      frame_done    <= 1'b0;
    end else begin
      frame_done <= (state_q == DRAIN) && out_xfer;
      if (in_xfer) begin
        m_axis_tdata  <= pix_data;
        m_axis_tuser  <= (x_q == '0) && (y_q == '0);
        m_axis_tlast  <= x_last;
        m_axis_tvalid <= 1'b1;
      end else if (out_xfer) begin
        m_axis_tvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_comperator_axi_ip_v1_0_frame_tx.sv
// Scoreboard bench for the frame transmitter: a 4x2 instance under
// randomized traffic plus a 1x1 instance for the single-pixel frame.
module tb_comperator_axi_ip_v1_0_frame_tx;

  localparam int DW = 24;
  localparam int H  = 4;
  localparam int V  = 2;
  localparam int HV = H * V;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          u;
    logic          l;
    logic          eof;
  } beat_t;

  logic          aclk = 1'b0;
  logic          aresetn;
  logic          go;
  logic [DW-1:0] pix_data;
  logic          pix_valid;
  logic          pix_ready;
  logic [DW-1:0] m_tdata;
  logic          m_tuser;
  logic          m_tlast;
  logic          m_tvalid;
  logic          m_tready;
  logic          busy;
  logic          frame_done;

  logic          go1;
  logic [DW-1:0] pd1;
  logic          pv1;
  logic          pr1;
  logic [DW-1:0] td1;
  logic          tu1;
  logic          tl1;
  logic          tv1;
  logic          trdy1;
  logic          busy1;
  logic          fd1;

  beat_t sb[$];
  beat_t sb1[$];
  int total = 0;
  int bad = 0;
  int n0 = 0;
  int exp_frames = 0;
  int got_frames = 0;
  int exp_frames1 = 0;
  int got_frames1 = 0;
  int rmode = 3;

  bit p_in, p_v, p_r, p_last, p_done, p_go, p_u, p_l;
  logic [DW-1:0] p_d;
  bit p_last1;

  always #5 aclk = ~aclk;

  comperator_axi_ip_v1_0_frame_tx #(
    .DATA_WIDTH(DW), .H_ACTIVE(H), .V_ACTIVE(V), .CNT_WIDTH(4)
  ) u_dut (
    .aclk(aclk), .aresetn(aresetn), .go(go),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .m_axis_tdata(m_tdata), .m_axis_tuser(m_tuser),
    .m_axis_tlast(m_tlast), .m_axis_tvalid(m_tvalid),
    .m_axis_tready(m_tready), .busy(busy), .frame_done(frame_done)
  );

  comperator_axi_ip_v1_0_frame_tx #(
    .DATA_WIDTH(DW), .H_ACTIVE(1), .V_ACTIVE(1), .CNT_WIDTH(2)
  ) u_dut1 (
    .aclk(aclk), .aresetn(aresetn), .go(go1),
    .pix_data(pd1), .pix_valid(pv1), .pix_ready(pr1),
    .m_axis_tdata(td1), .m_axis_tuser(tu1),
    .m_axis_tlast(tl1), .m_axis_tvalid(tv1),
    .m_axis_tready(trdy1), .busy(busy1), .frame_done(fd1)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Frame position n (raster order) fully determines the sideband bits.
  function automatic beat_t model(int n, int h, int v, logic [DW-1:0] d);
    beat_t b;
    b.d   = d;
    b.u   = (n == 0);
    b.l   = ((n % h) == h - 1);
    b.eof = (n == h * v - 1);
    return b;
  endfunction

  task automatic send(input logic [DW-1:0] d, input int gap);
    bit ok;
    ok = 0;
    for (int g = 0; g < gap; g++) begin
      pix_valid = 1'b0;
      @(posedge aclk);
      #1;
    end
    pix_valid = 1'b1;
    pix_data  = d;
    for (int t = 0; t < 400 && !ok; t++) begin
      @(negedge aclk);
      if (pix_ready) begin
        sb.push_back(model(n0, H, V, d));
        if (n0 == HV - 1) exp_frames++;
        n0 = (n0 + 1) % HV;
        @(posedge aclk);
        #1;
        ok = 1;
      end
    end
    pix_valid = 1'b0;
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL send_timeout: pixel %0h never accepted", d);
    end
  endtask

  task automatic go_pulse();
    @(posedge aclk);
    #1 go = 1'b1;
    @(posedge aclk);
    #1 go = 1'b0;
  endtask

  task automatic drain(input string nm);
    bit ok;
    ok = 0;
    for (int t = 0; t < 1000 && !ok; t++) begin
      @(negedge aclk);
      if (sb.size() == 0 && !m_tvalid) ok = 1;
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL %s_drain_timeout: %0d beats left", nm, sb.size());
    end
    repeat (3) @(negedge aclk);
    chk({nm, "_busy_low"}, 32'(busy), 32'd0);
  endtask

  initial begin
    forever begin
      @(posedge aclk);
      #1;
      case (rmode)
        0: m_tready = 1'b1;
        1: m_tready = !m_tready;
        2: m_tready = 1'($urandom_range(0, 1));
        default: m_tready = 1'b0;
      endcase
    end
  end

  // Monitor for the 4x2 instance.
  initial begin
    beat_t e;
    forever begin
      @(negedge aclk);
      if (!aresetn) begin
        p_in = 0; p_v = 0; p_r = 0; p_last = 0;
        p_done = 0; p_go = 0; p_u = 0; p_l = 0; p_d = '0;
      end else begin
        if (p_in) chk("latency_tvalid", 32'(m_tvalid), 32'd1);
        if (m_tvalid && !p_v)
          chk("tvalid_without_accept", 32'(p_in), 32'd1);
        if (p_v && !p_r) begin
          chk("stall_tvalid", 32'(m_tvalid), 32'd1);
          chk("stall_tdata", 32'(m_tdata), 32'(p_d));
          chk("stall_tuser", 32'(m_tuser), 32'(p_u));
          chk("stall_tlast", 32'(m_tlast), 32'(p_l));
        end
        if (m_tvalid && !m_tready)
          chk("stall_pix_ready", 32'(pix_ready), 32'd0);
        if (p_last || frame_done)
          chk("frame_done_pulse", 32'(frame_done), 32'(p_last));
        if (p_done && p_go)
          chk("restart_busy", 32'(busy), 32'd1);
        if (frame_done) got_frames++;
        p_last = 0;
        if (m_tvalid && m_tready) begin
          if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_beat: data %0h", m_tdata);
          end else begin
            e = sb.pop_front();
            chk("beat_tdata", 32'(m_tdata), 32'(e.d));
            chk("beat_tuser", 32'(m_tuser), 32'(e.u));
            chk("beat_tlast", 32'(m_tlast), 32'(e.l));
            p_last = e.eof;
          end
        end
        p_in   = pix_valid && pix_ready;
        p_v    = m_tvalid;
        p_r    = m_tready;
        p_d    = m_tdata;
        p_u    = m_tuser;
        p_l    = m_tlast;
        p_done = frame_done;
        p_go   = go;
      end
    end
  end

  // Monitor for the 1x1 instance.
  initial begin
    beat_t e;
    forever begin
      @(negedge aclk);
      if (!aresetn) begin
        p_last1 = 0;
      end else begin
        if (p_last1 || fd1)
          chk("frame_done1_pulse", 32'(fd1), 32'(p_last1));
        if (fd1) got_frames1++;
        p_last1 = 0;
        if (tv1 && trdy1) begin
          if (sb1.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_beat1: data %0h", td1);
          end else begin
            e = sb1.pop_front();
            chk("beat1_tdata", 32'(td1), 32'(e.d));
            chk("beat1_tuser", 32'(tu1), 32'(e.u));
            chk("beat1_tlast", 32'(tl1), 32'(e.l));
            p_last1 = e.eof;
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int hi;
    aresetn = 1'b0;
    go = 1'b0;
    pix_valid = 1'b0;
    pix_data = '0;
    go1 = 1'b0;
    pd1 = '0;
    pv1 = 1'b0;
    trdy1 = 1'b1;

    repeat (2) @(posedge aclk);
    #1;
    chk("rst_pix_ready", 32'(pix_ready), 32'd0);
    chk("rst_tdata", 32'(m_tdata), 32'd0);
    chk("rst_tuser", 32'(m_tuser), 32'd0);
    chk("rst_tlast", 32'(m_tlast), 32'd0);
    chk("rst_tvalid", 32'(m_tvalid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    @(negedge aclk);
    #2 aresetn = 1'b1;

    // Continuous valid, always ready.
    rmode = 0;
    go_pulse();
    for (int i = 1; i <= HV; i++) send(DW'(i), 0);
    drain("basic");

    // Ready toggling every cycle.
    rmode = 1;
    go_pulse();
    for (int i = 1; i <= HV; i++) send(DW'(i), 0);
    drain("toggle");

    // Valid one cycle in three.
    rmode = 0;
    go_pulse();
    for (int i = 1; i <= HV; i++) send(DW'(i), 2);
    drain("gaps");

    // go held across two frames with random ready.
    rmode = 2;
    @(posedge aclk);
    #1 go = 1'b1;
    for (int i = 0; i < 2 * HV; i++)
      send(DW'($urandom()), int'($urandom_range(0, 1)));
    go = 1'b0;
    drain("go_held");

    // Reset while beat 5 is stalled at the output.
    rmode = 0;
    go_pulse();
    for (int i = 1; i <= 4; i++) send(DW'(i), 0);
    ok = 0;
    for (int t = 0; t < 100 && !ok; t++) begin
      @(negedge aclk);
      if (sb.size() == 0 && !m_tvalid) ok = 1;
    end
    chk("pre_reset_drained", 32'(ok), 32'd1);
    rmode = 3;
    @(posedge aclk);
    #1;
    send(DW'(5), 0);
    ok = 0;
    for (int t = 0; t < 20 && !ok; t++) begin
      @(negedge aclk);
      if (m_tvalid) ok = 1;
    end
    chk("beat5_held", 32'(ok), 32'd1);
    #2 aresetn = 1'b0;
    #1;
    chk("mid_rst_pix_ready", 32'(pix_ready), 32'd0);
    chk("mid_rst_tdata", 32'(m_tdata), 32'd0);
    chk("mid_rst_tuser", 32'(m_tuser), 32'd0);
    chk("mid_rst_tlast", 32'(m_tlast), 32'd0);
    chk("mid_rst_tvalid", 32'(m_tvalid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_frame_done", 32'(frame_done), 32'd0);
    sb.delete();
    n0 = 0;
    rmode = 0;
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    #2 aresetn = 1'b1;
    hi = 0;
    repeat (6) begin
      @(negedge aclk);
      if (m_tvalid || busy) hi++;
    end
    chk("idle_after_reset", 32'(hi), 32'd0);
    go_pulse();
    for (int i = 1; i <= HV; i++) send(DW'(32'h10 + i), 0);
    drain("post_reset");

    // Random traffic frame.
    rmode = 2;
    go_pulse();
    for (int i = 0; i < HV; i++)
      send(DW'($urandom()), int'($urandom_range(0, 2)));
    drain("random");

    // Single-pixel frame on the 1x1 instance.
    @(posedge aclk);
    #1 go1 = 1'b1;
    @(posedge aclk);
    #1 go1 = 1'b0;
    pv1 = 1'b1;
    pd1 = 24'hABCDEF;
    ok = 0;
    for (int t = 0; t < 20 && !ok; t++) begin
      @(negedge aclk);
      if (pr1) begin
        sb1.push_back(model(0, 1, 1, pd1));
        exp_frames1++;
        @(posedge aclk);
        #1;
        ok = 1;
      end
    end
    pv1 = 1'b0;
    chk("one_pixel_accepted", 32'(ok), 32'd1);
    repeat (5) @(negedge aclk);
    chk("one_pixel_busy_low", 32'(busy1), 32'd0);
    chk("one_pixel_sb_empty", 32'(sb1.size()), 32'd0);
    chk("frames1_count", 32'(got_frames1), 32'(exp_frames1));

    chk("frames_count", 32'(got_frames), 32'(exp_frames));
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/comperator_axi_ip_v1_0_frame_tx.md
COMPERATOR_AXI_IP_V1_0_FRAME_TX -- requirements
Module: comperator_axi_ip_v1_0_frame_tx

Interface
REQ-001 Parameters SHALL be DATA_WIDTH, default 24, pixel width; H_ACTIVE, default 640, pixels per line; V_ACTIVE, default 480, lines per frame; CNT_WIDTH, default 12, width of the x/y counters, with H_ACTIVE and V_ACTIVE each ≤ 2^CNT_WIDTH.
REQ-002 The block SHALL use one clock; reset is asynchronous and active-low. Ports:
  aclk  input  1  clock, all logic on rising edge
  aresetn  input  1  asynchronous active-low reset
  go  input  1  start one frame, sampled in IDLE only
  pix_data  input  DATA_WIDTH  raw pixel from upstream
  pix_valid  input  1  pix_data valid
  pix_ready  output  1  block accepts pix_data this cycle
  m_axis_tdata  output  DATA_WIDTH  AXI4-Stream video pixel
  m_axis_tuser  output  1  start of frame, first pixel only
  m_axis_tlast  output  1  end of line, last pixel of each line
  m_axis_tvalid  output  1  output beat valid
  m_axis_tready  input  1  downstream ready
  busy  output  1  high in RUN or DRAIN
  frame_done  output  1  one-cycle pulse when the final beat of a frame is accepted downstream

Function
REQ-003 The FSM SHALL have states IDLE, RUN and DRAIN.
REQ-004 In IDLE: pix_ready=0; go=1 → RUN next cycle, x=0, y=0.
REQ-005 The output SHALL be one register stage (tdata/tuser/tlast/tvalid); in RUN, pix_ready = !m_axis_tvalid || m_axis_tready.
REQ-006 An input transfer SHALL occur when pix_valid && pix_ready; on the next edge: tdata=pix_data, tvalid=1, tuser=(x==0 && y==0), tlast=(x==H_ACTIVE-1). Latency from input transfer to tvalid is 1 cycle.
REQ-007 An output transfer SHALL occur when m_axis_tvalid && m_axis_tready; with no simultaneous input transfer, tvalid SHALL clear on the next edge.
REQ-008 Simultaneous input and output transfer SHALL reload the register with no bubble (one beat per cycle sustained).
REQ-009 While tvalid=1 and tready=0, tdata/tuser/tlast SHALL hold stable.
REQ-010 Per input transfer: if x==H_ACTIVE-1 then x=0 and y=y+1, else x=x+1; counters SHALL never exceed H_ACTIVE-1 / V_ACTIVE-1.
REQ-011 An input transfer at x==H_ACTIVE-1 and y==V_ACTIVE-1 SHALL move to DRAIN; y resets to 0; pix_ready=0 in DRAIN.
REQ-012 In DRAIN, the output transfer of the last beat SHALL pulse frame_done for exactly one cycle (registered, the cycle after the transfer) and return to IDLE.
REQ-013 go SHALL be ignored in RUN and DRAIN; go held high in IDLE after a frame starts the next frame immediately.
REQ-014 Exactly H_ACTIVE*V_ACTIVE beats SHALL be emitted per frame, exactly one with tuser=1 and exactly V_ACTIVE with tlast=1.
REQ-015 H_ACTIVE=1 SHALL give tuser and tlast both high on the first beat; V_ACTIVE=1 SHALL end the frame after one line.

Reset
REQ-016 aresetn=0 SHALL asynchronously force IDLE, x=0, y=0, and all outputs (pix_ready, m_axis_tdata, m_axis_tuser, m_axis_tlast, m_axis_tvalid, busy, frame_done) to 0.
REQ-017 Reset mid-frame SHALL discard the held beat and partial frame; after release, no beat is emitted until go.

Verification
REQ-018 H=4,V=2, go pulse, pix_valid=1 constant, tready=1, data 1..8 → 8 beats on consecutive cycles, first tvalid 1 cycle after first accept, tuser only on data 1, tlast on 4 and 8, frame_done 1 cycle after beat 8, busy low after.
REQ-019 Same config, tready toggling 1/0 each cycle → beats 1..8 in order, data stable while stalled, no loss or duplication, pix_ready low whenever tvalid=1 and tready=0.
REQ-020 pix_valid gaps (valid 1 of every 3 cycles), tready=1 → tvalid asserted only after accepts, same tuser/tlast positions as REQ-018.
REQ-021 go=1 during RUN and DRAIN → ignored; go held high continuously → second frame starts the cycle after return to IDLE, its first beat has tuser=1.
REQ-022 aresetn low after beat 5 with tvalid=1 and tready=0 → all outputs 0 immediately; next go yields a fresh frame starting with tuser=1 at x=0,y=0.
REQ-023 H=1,V=1, single pixel 0xABCDEF → one beat with tuser=1, tlast=1, then frame_done pulse.
